// File: rtl/rr_dispatch_pkg.sv
// Shared types and helpers for the rr_arbiter grant dispatch stage.
package rr_dispatch_pkg;

  localparam int ERR_MULTI   = 0;
  localparam int ERR_STALL   = 1;
  localparam int MAX_CLIENTS = 1024;
  localparam int MAX_IDX_W   = 10;

  function automatic int IDX_W(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // OR-reduce the set bit positions; exact for one-hot inputs
  function automatic logic [MAX_IDX_W-1:0] onehot2idx(input logic [MAX_CLIENTS-1:0] oh);
    logic [MAX_IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_CLIENTS; i++)
      if (oh[i]) idx |= MAX_IDX_W'(i);
    return idx;
  endfunction

  // Entry layout for the default 32-client, 32-bit configuration
  typedef struct packed {
    logic [IDX_W(32)-1:0] idx;
    logic [31:0]          data;
  } entry_t;

endpackage

// File: rtl/rr_dispatch_fifo.sv
// Generic synchronous FIFO of an arbitrary packed type; storage cleared on reset.
module rr_dispatch_fifo #(
  parameter type T     = logic [7:0],
  parameter int  DEPTH = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          push,
  input  T              din,
  input  logic          pop,
  output T              dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  T            mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic        do_push, do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/rr_grant_dispatch.sv
// Encodes rr_arbiter's one-hot grant, queues {index, payload}, backpressures via stall.
// Optional same-cycle bypass when empty: RR_GRANT_DISPATCH_BYPASS_EN.
module rr_grant_dispatch
  import rr_dispatch_pkg::*;
#(
  parameter int CLIENTS = 32,
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 4
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [CLIENTS-1:0]          grant,
  input  logic [CLIENTS*DATA_W-1:0]   req_data,
  output logic                        stall,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [IDX_W(CLIENTS)-1:0]   out_index,
  output logic [DATA_W-1:0]           out_data,
  output logic [1:0]                  err
);

  localparam int IW = IDX_W(CLIENTS);
  localparam int CW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [IW-1:0]     idx;
    logic [DATA_W-1:0] data;
  } ent_t;

  logic          legal, multi, push, pop, byp;
  logic          fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;
  ent_t          wr_ent, head, out_ent;

  assign legal       = $onehot(grant);
  assign multi       = (grant != '0) && !legal;
  assign wr_ent.idx  = IW'(onehot2idx(MAX_CLIENTS'(grant)));
  assign wr_ent.data = req_data[wr_ent.idx*DATA_W +: DATA_W];

  // Registered occupancy only, so stall has no path from grant or out_ready
  assign stall = (fifo_count == CW'(DEPTH));

`ifdef RR_GRANT_DISPATCH_BYPASS_EN
  assign byp = fifo_empty && out_ready && legal;
`else
  assign byp = 1'b0;
`endif

  assign push      = legal && !fifo_full && !byp;
  assign pop       = !fifo_empty && out_ready;
  assign out_ent   = byp ? wr_ent : head;
  assign out_valid = !fifo_empty || byp;
  assign out_index = out_ent.idx;
  assign out_data  = out_ent.data;

  always_ff @(posedge clock) begin
    if (reset) begin
      err <= '0;
    end else begin
      if (multi)                   err[ERR_MULTI] <= 1'b1;
      if ((grant != '0) && stall)  err[ERR_STALL] <= 1'b1;
    end
  end

  rr_dispatch_fifo #(.T(ent_t), .DEPTH(DEPTH)) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .din   (wr_ent),
    .pop   (pop),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

endmodule
